dec_key_schedule: RTL and testbench

Round-key generator for the AES-128 inverse-cipher datapath. Expands a 128-bit cipher key into all 11 round keys, buffers them, then serves them in decryption order (round 10 down to round 0), one per request. It feeds the `key` operand of the round-key XOR stage on the decrypt path, which needs keys in the reverse order of the encrypt path.

---
 rtl/aes_pkg.sv | 29 ++
 rtl/aes_sbox.sv | 28 ++
 rtl/dec_key_schedule.sv | 151 +++++++++++++++
 tb/tb_dec_key_schedule.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, round constants, key-schedule
// state encoding and the round-key container type.
package aes_pkg;

  localparam int NR = 10;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } ks_state_e;

  typedef logic [0:127] round_key_t;

  // Round constant for round r (1..NR); zero outside that range.
  function automatic logic [7:0] rcon_f(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 1; i <= NR; i++) begin
      if (r == 4'(i)) v = RCON[i];
    end
    return v;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational 8-bit lookup.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign s_o = SBOX[a_i];

endmodule

// File: rtl/dec_key_schedule.sv
// AES-128 decrypt-side key schedule: expands a cipher key one round per
// cycle into an 11-entry buffer, then serves round keys 10 down to 0 on
// request, wrapping back to 10 so the same key serves the next block.
module dec_key_schedule #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:127] key_in,
  input  logic         key_load,
  input  logic         rk_req,
  output logic         busy,
  output logic         ready,
  output logic         rk_valid,
  output logic [0:127] rk_out,
  output logic [3:0]   rk_index,
  output logic         rk_last
);

  import aes_pkg::*;

  ks_state_e  state_q, state_d;
  logic [3:0] r_q, r_d;
  logic [3:0] p_q, p_d;
  logic       busy_q, ready_q;
  logic       rk_valid_q, rk_valid_d;
  logic       rk_last_q, rk_last_d;
  logic [3:0] rk_index_q, rk_index_d;
  round_key_t rk_out_q, rk_out_d;

  logic       load_acc;
  logic       exp_wr;

  // Key storage and the working copy of the previous round key; the working
  // copy avoids an 11:1 read mux on the expansion path.
  round_key_t key_buf [0:NR];
  round_key_t cur_q;
  round_key_t next_key;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = cur_q[0:31];
  assign w1 = cur_q[32:63];
  assign w2 = cur_q[64:95];
  assign w3 = cur_q[96:127];

  assign rot_w = {w3[23:0], w3[31:24]};

  aes_sbox u_sbox0 (.a_i(rot_w[31:24]), .s_o(sub_w[31:24]));
  aes_sbox u_sbox1 (.a_i(rot_w[23:16]), .s_o(sub_w[23:16]));
  aes_sbox u_sbox2 (.a_i(rot_w[15:8]),  .s_o(sub_w[15:8]));
  aes_sbox u_sbox3 (.a_i(rot_w[7:0]),   .s_o(sub_w[7:0]));

  assign n0 = w0 ^ sub_w ^ {rcon_f(r_q), 24'h0};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // Next-state, counters and readout decisions.
  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    p_d        = p_q;
    rk_valid_d = 1'b0;
    rk_last_d  = 1'b0;
    rk_index_d = rk_index_q;
    rk_out_d   = rk_out_q;
    load_acc   = 1'b0;
    exp_wr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_load) begin
          load_acc = 1'b1;
          state_d  = EXPAND;
          r_d      = 4'd1;
        end
      end
      EXPAND: begin
        exp_wr = 1'b1;
        if (r_q == 4'(NR)) begin
          state_d = READY;
          p_d     = 4'(NR);
        end else begin
          r_d = r_q + 4'd1;
        end
      end
      READY: begin
        // A reload takes priority over serving a key in the same cycle.
        if (key_load) begin
          load_acc = 1'b1;
          state_d  = EXPAND;
          r_d      = 4'd1;
        end else if (rk_req) begin
          rk_valid_d = 1'b1;
          rk_out_d   = key_buf[p_q];
          rk_index_d = p_q;
          rk_last_d  = (p_q == 4'd0);
          p_d        = (p_q == 4'd0) ? 4'(NR) : p_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers, cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      r_q        <= 4'd0;
      p_q        <= 4'(NR);
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
      rk_index_q <= 4'd0;
      rk_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      p_q        <= p_d;
      busy_q     <= (state_d == EXPAND);
      ready_q    <= (state_d == READY);
      rk_valid_q <= rk_valid_d;
      rk_last_q  <= rk_last_d;
      rk_index_q <= rk_index_d;
      rk_out_q   <= rk_out_d;
    end
  end

  // Key buffer writes: the cipher key on load, one expanded round per cycle.
  always_ff @(posedge clk) begin
    if (load_acc) begin
      key_buf[0] <= key_in;
      cur_q      <= key_in;
    end else if (exp_wr) begin
      key_buf[r_q] <= next_key;
      cur_q        <= next_key;
    end
  end

  assign busy     = busy_q;
  assign ready    = ready_q;
  assign rk_valid = rk_valid_q;
  assign rk_last  = rk_last_q;
  assign rk_index = rk_index_q;
  assign rk_out   = rk_out_q;

endmodule

// File: tb/tb_dec_key_schedule.sv
// Bench for dec_key_schedule: FIPS-197 directed vectors plus a
// cycle-by-cycle comparison against a behavioural key-schedule model.
module tb_dec_key_schedule;

  logic         clk;
  logic         rst;
  logic [0:127] key_in;
  logic         key_load;
  logic         rk_req;
  logic         busy;
  logic         ready;
  logic         rk_valid;
  logic [0:127] rk_out;
  logic [3:0]   rk_index;
  logic         rk_last;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  int n_checks = 0;
  int n_errors = 0;

  dec_key_schedule #(.NR(10)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .rk_req(rk_req), .busy(busy), .ready(ready), .rk_valid(rk_valid),
    .rk_out(rk_out), .rk_index(rk_index), .rk_last(rk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (FIPS-197 word recurrence) ----------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, x;
    acc = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox_m(input logic [7:0] a);
    logic [7:0] inv, s;
    inv = 8'h01;
    if (a == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    s = 8'h63;
    for (int n = 0; n < 5; n++) begin
      logic [7:0] rl;
      rl = (n == 0) ? inv : ((inv << n) | (inv >> (8 - n)));
      s = s ^ rl;
    end
    return s;
  endfunction

  function automatic logic [7:0] rcon_m(input int r);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 1; i < r; i++) rc = xtime(rc);
    return rc;
  endfunction

  function automatic void expand_key(input logic [127:0] k, output logic [127:0] ks [0:10]);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m(t[31:24]), sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0])};
        t = t ^ {rcon_m(i / 4), 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // m_cnt: cycles since the accepted load (0 = never loaded); busy for 1..10.
  int           m_cnt;
  int           m_ptr;
  logic [127:0] m_keys [0:10];
  logic         e_busy, e_ready, e_valid, e_last;
  logic [127:0] e_out;
  logic [3:0]   e_idx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt   = 0;
      m_ptr   = 10;
      e_valid = 1'b0;
      e_last  = 1'b0;
      e_out   = '0;
      e_idx   = 4'd0;
    end else begin
      e_valid = 1'b0;
      e_last  = 1'b0;
      if (key_load && !(m_cnt >= 1 && m_cnt <= 10)) begin
        expand_key(key_in, m_keys);
        m_cnt = 1;
      end else if (m_cnt >= 11 && rk_req) begin
        e_valid = 1'b1;
        e_out   = m_keys[m_ptr];
        e_idx   = 4'(m_ptr);
        e_last  = (m_ptr == 0);
        m_ptr   = (m_ptr == 0) ? 10 : m_ptr - 1;
      end else if (m_cnt >= 1 && m_cnt <= 10) begin
        m_cnt++;
        if (m_cnt == 11) m_ptr = 10;
      end
    end
    e_busy  = (m_cnt >= 1 && m_cnt <= 10);
    e_ready = (m_cnt >= 11);
  end

  always @(negedge clk) begin
    chk("busy", 128'(busy), 128'(e_busy));
    chk("ready", 128'(ready), 128'(e_ready));
    chk("busy_and_ready", 128'(busy & ready), 128'(1'b0));
    chk("rk_valid", 128'(rk_valid), 128'(e_valid));
    chk("rk_last", 128'(rk_last), 128'(e_last));
    chk("rk_index", 128'(rk_index), 128'(e_idx));
    chk("rk_out", rk_out, e_out);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus -------------------------------------
  initial begin
    logic [127:0] ks [0:10];
    rst = 1'b1;
    key_in = '0;
    key_load = 1'b0;
    rk_req = 1'b0;

    // Pin the model against FIPS-197 values.
    expand_key(FIPS_KEY, ks);
    chk("model_fips_rk10", ks[10], FIPS_RK10);
    chk("model_fips_rk1", ks[1], FIPS_RK1);
    chk("model_fips_rk0", ks[0], FIPS_KEY);
    expand_key('0, ks);
    chk("model_zero_rk10", ks[10], ZERO_RK10);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_ready", 128'(ready), 128'(0));
    chk("reset_valid", 128'(rk_valid), 128'(0));
    chk("reset_out", rk_out, 128'h0);
    chk("reset_index", 128'(rk_index), 128'(0));
    rst = 1'b0;

    // Requests in IDLE are ignored.
    rk_req = 1'b1;
    tick();
    tick();
    chk("idle_req_valid", 128'(rk_valid), 128'(0));
    rk_req = 1'b0;

    // Load FIPS key; hold requests and re-load mid-expansion.
    key_in = FIPS_KEY;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    rk_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      chk("exp_busy", 128'(busy), 128'(1));
      chk("exp_ready", 128'(ready), 128'(0));
      chk("exp_valid", 128'(rk_valid), 128'(0));
      if (k == 4) begin
        key_load = 1'b1;
        key_in = '0;
      end else begin
        key_load = 1'b0;
      end
      tick();
    end
    chk("done_busy", 128'(busy), 128'(0));
    chk("done_ready", 128'(ready), 128'(1));

    for (int i = 0; i <= 10; i++) begin
      tick();
      if (i == 10) rk_req = 1'b0;
      chk("rd_valid", 128'(rk_valid), 128'(1));
      chk("rd_index", 128'(rk_index), 128'(10 - i));
      if (i == 0) chk("rd_fips_rk10", rk_out, FIPS_RK10);
      if (i == 9) chk("rd_fips_rk1", rk_out, FIPS_RK1);
      if (i == 10) begin
        chk("rd_fips_rk0", rk_out, FIPS_KEY);
        chk("rd_last", 128'(rk_last), 128'(1));
      end
    end
    tick();
    chk("rd_stop_valid", 128'(rk_valid), 128'(0));

    // 22 back-to-back requests: two full decrypt sequences.
    rk_req = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (i == 21) rk_req = 1'b0;
      chk("b2b_valid", 128'(rk_valid), 128'(1));
      chk("b2b_index", 128'(rk_index), 128'(10 - (i % 11)));
      chk("b2b_last", 128'(rk_last), 128'((i == 10) || (i == 21)));
    end
    tick();
    chk("b2b_stop_valid", 128'(rk_valid), 128'(0));

    // Asynchronous reset in the middle of expansion (r = 6).
    key_in = FIPS_KEY;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_ready", 128'(ready), 128'(0));
    chk("arst_valid", 128'(rk_valid), 128'(0));
    chk("arst_last", 128'(rk_last), 128'(0));
    chk("arst_out", rk_out, 128'h0);
    chk("arst_index", 128'(rk_index), 128'(0));
    rst = 1'b0;
    tick();
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    repeat (10) tick();
    chk("reload_ready", 128'(ready), 128'(1));
    rk_req = 1'b1;
    tick();
    rk_req = 1'b0;
    chk("reload_valid", 128'(rk_valid), 128'(1));
    chk("reload_index", 128'(rk_index), 128'(10));
    chk("reload_rk10", rk_out, FIPS_RK10);

    // Load and request together in READY: load wins.
    key_in = '0;
    key_load = 1'b1;
    rk_req = 1'b1;
    tick();
    key_load = 1'b0;
    rk_req = 1'b0;
    chk("ldreq_valid", 128'(rk_valid), 128'(0));
    chk("ldreq_busy", 128'(busy), 128'(1));
    repeat (10) tick();
    chk("zero_ready", 128'(ready), 128'(1));
    rk_req = 1'b1;
    tick();
    rk_req = 1'b0;
    chk("zero_valid", 128'(rk_valid), 128'(1));
    chk("zero_index", 128'(rk_index), 128'(10));
    chk("zero_rk10", rk_out, ZERO_RK10);
    tick();
    chk("zero_stop_valid", 128'(rk_valid), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
